// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module : cpu_pkg
//  Brief  : Shared opcodes, ALU operation encodings, flag bit indices and the
//           decoded control bundle for the LEGv8-subset CPU front end.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Opcode field values, grouped by field width (longest first)
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;

    // Condition code for B.LT
    localparam logic [4:0]  COND_LT  = 5'b01011;

    // ALU operation encodings
    localparam logic [2:0]  ALU_PASSB = 3'b000;
    localparam logic [2:0]  ALU_ADD   = 3'b010;
    localparam logic [2:0]  ALU_SUB   = 3'b011;
    localparam logic [2:0]  ALU_AND   = 3'b100;
    localparam logic [2:0]  ALU_OR    = 3'b101;
    localparam logic [2:0]  ALU_XOR   = 3'b110;

    // Stored flag bit indices
    localparam int FLG_N = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_V = 2;
    localparam int FLG_C = 3;

    // Decoded datapath control bundle
    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       alusrc1;
        logic       memtoreg;
        logic       regwrite;
        logic       memwri;
        logic       readmem;
        logic       brtaken;
        logic       uncondbr;
        logic       enflags;
        logic       writerd;
        logic       br;
        logic [2:0] aluop;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
//  Module : pc_reg
//  Brief  : Program-counter register with asynchronous active-high reset to
//           a parameterised value and a synchronous load enable.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_reg #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_en,
    input  logic [PC_W-1:0] pc_next,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next value: load when enabled, otherwise hold
    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            pc_d = pc_next;
        end
    end

    // State register; reset acts immediately, independent of the clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/decode_pc_unit.sv
// ============================================================================
//  Module : decode_pc_unit
//  Brief  : CPU front end: PC register, instruction decoder and immediate
//           extender. Decode and extension are purely combinational.
//  Config : DECODE_ILLEGAL_FLAG_EN adds the illegal_op output.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_pc_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
`ifdef DECODE_ILLEGAL_FLAG_EN
    output logic            illegal_op,
`endif
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_en,
    input  logic [PC_W-1:0] pc_next,
    output logic [PC_W-1:0] pc,
    input  logic [31:0]     instruction,
    input  logic            zero,
    input  logic [3:0]      flag,
    output logic            Reg2Loc,
    output logic            ALUsrc,
    output logic            ALUsrc1,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemWri,
    output logic            Readmem,
    output logic            BrTaken,
    output logic            UncondBr,
    output logic            enFlags,
    output logic            WriteRd,
    output logic            BR,
    output logic [2:0]      ALUOp,
    output logic [63:0]     DAddr9,
    output logic [63:0]     CondAddr19,
    output logic [63:0]     BrAddr26,
    output logic [63:0]     Imm12
);

    ctrl_t w_ctrl;
    logic  w_illegal;

    // Zero and carry flags are stored but no decoded branch looks at them
    logic  w_unused_flags;
    assign w_unused_flags = flag[FLG_Z] ^ flag[FLG_C];

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .pc_en   (pc_en),
        .pc_next (pc_next),
        .pc      (pc)
    );

    // Opcode decode, longest opcode field matched first
    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        if (instruction[31:21] == OP_ADDS) begin
            w_ctrl.reg2loc  = 1'b1;
            w_ctrl.regwrite = 1'b1;
            w_ctrl.enflags  = 1'b1;
            w_ctrl.aluop    = ALU_ADD;
        end else if (instruction[31:21] == OP_SUBS) begin
            w_ctrl.reg2loc  = 1'b1;
            w_ctrl.regwrite = 1'b1;
            w_ctrl.enflags  = 1'b1;
            w_ctrl.aluop    = ALU_SUB;
        end else if (instruction[31:21] == OP_LDUR) begin
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.memtoreg = 1'b1;
            w_ctrl.regwrite = 1'b1;
            w_ctrl.readmem  = 1'b1;
            w_ctrl.aluop    = ALU_ADD;
        end else if (instruction[31:21] == OP_STUR) begin
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.memwri   = 1'b1;
            w_ctrl.aluop    = ALU_ADD;
        end else if (instruction[31:21] == OP_BR) begin
            // Target register sits in [4:0], which is port 2 with Reg2Loc=0
            w_ctrl.br       = 1'b1;
        end else if (instruction[31:22] == OP_ADDI) begin
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.alusrc1  = 1'b1;
            w_ctrl.regwrite = 1'b1;
            w_ctrl.aluop    = ALU_ADD;
        end else if (instruction[31:24] == OP_CBZ) begin
            w_ctrl.aluop    = ALU_PASSB;
            w_ctrl.brtaken  = zero;
        end else if (instruction[31:24] == OP_BCOND) begin
            // Only LT is supported; any other condition never branches
            if (instruction[4:0] == COND_LT) begin
                w_ctrl.brtaken = flag[FLG_N] ^ flag[FLG_V];
            end
        end else if (instruction[31:26] == OP_B) begin
            w_ctrl.brtaken  = 1'b1;
            w_ctrl.uncondbr = 1'b1;
        end else if (instruction[31:26] == OP_BL) begin
            w_ctrl.brtaken  = 1'b1;
            w_ctrl.uncondbr = 1'b1;
            w_ctrl.regwrite = 1'b1;
            w_ctrl.writerd  = 1'b1;
        end else begin
            w_illegal = 1'b1;
        end
    end

    // Immediate extraction; shifting by 2 for branch offsets happens downstream
    always_comb begin
        DAddr9     = {{55{instruction[20]}}, instruction[20:12]};
        CondAddr19 = {{45{instruction[23]}}, instruction[23:5]};
        BrAddr26   = {{38{instruction[25]}}, instruction[25:0]};
        Imm12      = {52'd0, instruction[21:10]};
    end

    assign Reg2Loc  = w_ctrl.reg2loc;
    assign ALUsrc   = w_ctrl.alusrc;
    assign ALUsrc1  = w_ctrl.alusrc1;
    assign MemtoReg = w_ctrl.memtoreg;
    assign RegWrite = w_ctrl.regwrite;
    assign MemWri   = w_ctrl.memwri;
    assign Readmem  = w_ctrl.readmem;
    assign BrTaken  = w_ctrl.brtaken;
    assign UncondBr = w_ctrl.uncondbr;
    assign enFlags  = w_ctrl.enflags;
    assign WriteRd  = w_ctrl.writerd;
    assign BR       = w_ctrl.br;
    assign ALUOp    = w_ctrl.aluop;

`ifdef DECODE_ILLEGAL_FLAG_EN
    assign illegal_op = w_illegal;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = w_illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_pc_unit.sv
// ============================================================================
//  Module : tb_decode_pc_unit
//  Brief  : Self-checking bench for decode_pc_unit: mnemonic-level reference
//           model compared every cycle, plus hand-computed literal checks.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_pc_unit;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       alusrc1;
        logic       memtoreg;
        logic       regwrite;
        logic       memwri;
        logic       readmem;
        logic       brtaken;
        logic       uncondbr;
        logic       enflags;
        logic       writerd;
        logic       br;
        logic [2:0] aluop;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en;
    logic [63:0] pc_next;
    logic [63:0] pc;
    logic [31:0] instruction;
    logic        zero;
    logic [3:0]  flag;
    logic        Reg2Loc, ALUsrc, ALUsrc1, MemtoReg, RegWrite, MemWri, Readmem;
    logic        BrTaken, UncondBr, enFlags, WriteRd, BR;
    logic [2:0]  ALUOp;
    logic [63:0] DAddr9, CondAddr19, BrAddr26, Imm12;
`ifdef DECODE_ILLEGAL_FLAG_EN
    logic        illegal_op;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_pc;
    logic        run_cmp = 1'b0;

    always #5 clk = ~clk;

    decode_pc_unit #(.PC_W(64), .RESET_PC(64'd0)) dut (
`ifdef DECODE_ILLEGAL_FLAG_EN
        .illegal_op  (illegal_op),
`endif
        .clk         (clk),
        .reset       (reset),
        .pc_en       (pc_en),
        .pc_next     (pc_next),
        .pc          (pc),
        .instruction (instruction),
        .zero        (zero),
        .flag        (flag),
        .Reg2Loc     (Reg2Loc),
        .ALUsrc      (ALUsrc),
        .ALUsrc1     (ALUsrc1),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .MemWri      (MemWri),
        .Readmem     (Readmem),
        .BrTaken     (BrTaken),
        .UncondBr    (UncondBr),
        .enFlags     (enFlags),
        .WriteRd     (WriteRd),
        .BR          (BR),
        .ALUOp       (ALUOp),
        .DAddr9      (DAddr9),
        .CondAddr19  (CondAddr19),
        .BrAddr26    (BrAddr26),
        .Imm12       (Imm12)
    );

    // ---------------- reference model ----------------
    function automatic string mnemonic(input logic [31:0] ins);
        int unsigned w = ins;
        if ((w >> 21) == 32'h558) return "ADDS";
        if ((w >> 21) == 32'h758) return "SUBS";
        if ((w >> 21) == 32'h7C2) return "LDUR";
        if ((w >> 21) == 32'h7C0) return "STUR";
        if ((w >> 21) == 32'h6B0) return "BR";
        if ((w >> 22) == 32'h244) return "ADDI";
        if ((w >> 24) == 32'hB4)  return "CBZ";
        if ((w >> 24) == 32'h54)  return "BCOND";
        if ((w >> 26) == 32'h05)  return "B";
        if ((w >> 26) == 32'h25)  return "BL";
        return "NOP";
    endfunction

    function automatic exp_t model_ctrl(input logic [31:0] ins, input logic z, input logic [3:0] f);
        exp_t e = '0;
        case (mnemonic(ins))
            "ADDI":  begin e.alusrc = 1; e.alusrc1 = 1; e.regwrite = 1; e.aluop = 3'd2; end
            "ADDS":  begin e.reg2loc = 1; e.regwrite = 1; e.enflags = 1; e.aluop = 3'd2; end
            "SUBS":  begin e.reg2loc = 1; e.regwrite = 1; e.enflags = 1; e.aluop = 3'd3; end
            "LDUR":  begin e.alusrc = 1; e.memtoreg = 1; e.regwrite = 1; e.readmem = 1; e.aluop = 3'd2; end
            "STUR":  begin e.alusrc = 1; e.memwri = 1; e.aluop = 3'd2; end
            "B":     begin e.brtaken = 1; e.uncondbr = 1; end
            "BL":    begin e.brtaken = 1; e.uncondbr = 1; e.regwrite = 1; e.writerd = 1; end
            "CBZ":   e.brtaken = z;
            "BCOND": e.brtaken = ((ins & 32'h1F) == 32'd11) && (f[0] != f[2]);
            "BR":    e.br = 1;
            default: ;
        endcase
        return e;
    endfunction

    // Sign extension by arithmetic: subtract 2^n when the top bit of the field is set
    function automatic logic [63:0] sext(input logic [63:0] field, input int n);
        logic [63:0] v = field;
        if (v >= (64'd1 << (n - 1))) v = v - (64'd1 << n);
        return v;
    endfunction

    function automatic logic [63:0] fld(input logic [31:0] ins, input int lo, input int n);
        return (64'(ins) >> lo) & ((64'd1 << n) - 64'd1);
    endfunction

    // PC scoreboard: async reset to 0, load on enabled edges
    always @(posedge clk or posedge reset) begin
        if (reset) exp_pc <= 64'd0;
        else if (pc_en) exp_pc <= pc_next;
    end

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        if (run_cmp) begin
            exp_t e;
            exp_t a;
            e = model_ctrl(instruction, zero, flag);
            a = {Reg2Loc, ALUsrc, ALUsrc1, MemtoReg, RegWrite, MemWri, Readmem,
                 BrTaken, UncondBr, enFlags, WriteRd, BR, ALUOp};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL ctrl ins=%h: got %b expected %b", instruction, a, e);
            end
            n_cmp++;
            if (DAddr9 !== sext(fld(instruction, 12, 9), 9) ||
                CondAddr19 !== sext(fld(instruction, 5, 19), 19) ||
                BrAddr26 !== sext(fld(instruction, 0, 26), 26) ||
                Imm12 !== fld(instruction, 10, 12)) begin
                n_err++;
                $display("FAIL imm ins=%h: got %h %h %h %h", instruction, DAddr9, CondAddr19, BrAddr26, Imm12);
            end
            n_cmp++;
            if (pc !== exp_pc) begin
                n_err++;
                $display("FAIL pc: got %h expected %h", pc, exp_pc);
            end
`ifdef DECODE_ILLEGAL_FLAG_EN
            n_cmp++;
            if (illegal_op !== (mnemonic(instruction) == "NOP")) begin
                n_err++;
                $display("FAIL illegal ins=%h: got %b", instruction, illegal_op);
            end
`endif
        end
    end

    // ---------------- literal checks ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic z, input logic [3:0] f);
        instruction = ins;
        zero        = z;
        flag        = f;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        pc_en       = 1'b0;
        pc_next     = 64'd0;
        instruction = 32'd0;
        zero        = 1'b0;
        flag        = 4'd0;
        repeat (2) next_cycle();
        run_cmp = 1'b1;
        chk("reset_pc", pc, 64'd0);

        // PC load, mid-cycle async reset, reload, hold
        reset = 1'b0; pc_en = 1'b1; pc_next = 64'h40;
        next_cycle();
        chk("pc_load_40", pc, 64'h40);
        pc_next = 64'h99;
        reset   = 1'b1;
        #1;
        chk("async_reset", pc, 64'd0);
        #1;
        reset   = 1'b0;
        pc_next = 64'd4;
        next_cycle();
        chk("pc_load_4", pc, 64'd4);
        pc_en   = 1'b0;
        pc_next = 64'd8;
        next_cycle();
        chk("pc_hold", pc, 64'd4);
        pc_en   = 1'b1;

        // ADDI X1,X0,#4095
        drive(32'h913FFC01, 1'b0, 4'd0);
        chk("addi_ctrl", {ALUsrc, ALUsrc1, RegWrite, ALUOp}, {3'b111, 3'b010});
        chk("addi_imm12", Imm12, 64'hFFF);
        next_cycle();

        // LDUR X2,[X1,#-8]
        drive({11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd2}, 1'b0, 4'd0);
        chk("ldur_ctrl", {MemtoReg, Readmem, RegWrite, MemWri}, 4'b1110);
        chk("ldur_daddr9", DAddr9, 64'hFFFF_FFFF_FFFF_FFF8);
        next_cycle();

        // CBZ X3,-1 with zero set, then clear
        drive({8'b10110100, 19'h7FFFF, 5'd3}, 1'b1, 4'd0);
        chk("cbz_condaddr", CondAddr19, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("cbz_taken", {BrTaken, UncondBr}, 2'b10);
        next_cycle();
        drive({8'b10110100, 19'h7FFFF, 5'd3}, 1'b0, 4'd0);
        chk("cbz_not_taken", {BrTaken, UncondBr}, 2'b00);
        next_cycle();

        // B.LT with N=1,V=0 then N=1,V=1; non-LT condition never taken
        drive({8'b01010100, 19'd4, 5'b01011}, 1'b0, 4'b0001);
        chk("blt_taken", BrTaken, 64'd1);
        next_cycle();
        drive({8'b01010100, 19'd4, 5'b01011}, 1'b0, 4'b0101);
        chk("blt_not_taken", BrTaken, 64'd0);
        next_cycle();
        drive({8'b01010100, 19'd4, 5'b00000}, 1'b0, 4'b0001);
        next_cycle();

        // BL #2
        drive({6'b100101, 26'd2}, 1'b0, 4'd0);
        chk("bl_ctrl", {BrTaken, UncondBr, WriteRd, RegWrite}, 4'b1111);
        chk("bl_braddr", BrAddr26, 64'd2);
        next_cycle();

        // B #-2
        drive({6'b000101, 26'h3FFFFFE}, 1'b0, 4'd0);
        chk("b_braddr_neg", BrAddr26, 64'hFFFF_FFFF_FFFF_FFFE);
        next_cycle();

        // Remaining opcodes checked by the model only
        drive({11'b10101011000, 5'd3, 6'd0, 5'd1, 5'd2}, 1'b0, 4'd0);   // ADDS
        next_cycle();
        drive({11'b11101011000, 5'd3, 6'd0, 5'd1, 5'd2}, 1'b0, 4'd0);   // SUBS
        chk("subs_aluop", ALUOp, 64'd3);
        next_cycle();
        drive({11'b11111000000, 9'h0FF, 2'b00, 5'd4, 5'd5}, 1'b0, 4'd0); // STUR
        next_cycle();
        drive({11'b11010110000, 16'd0, 5'd30}, 1'b0, 4'd0);              // BR X30
        chk("br_ctrl", {BR, RegWrite, BrTaken}, 3'b100);
        next_cycle();
        drive(32'hFFFF_FFFF, 1'b1, 4'hF);                                 // unrecognised
        next_cycle();

        // All-zero word decodes as NOP
        drive(32'd0, 1'b1, 4'b0001);
        chk("nop_enables", {RegWrite, MemWri, Readmem, BrTaken, BR, enFlags}, 6'd0);
`ifdef DECODE_ILLEGAL_FLAG_EN
        chk("nop_illegal", illegal_op, 64'd1);
`endif
        next_cycle();

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
